// File: rtl/pkg_extend_index.sv
// Shared types and constants for the index-compressed stream join unit.
package pkg_extend_index;

  localparam int WIDTH_INDEX = 8;

  parameter logic JOIN_INTERSECT = 1'b0;
  parameter logic JOIN_UNION     = 1'b1;

  typedef enum logic [2:0] {
    JOIN_IDLE    = 3'd0,
    JOIN_CMP     = 3'd1,
    JOIN_DRAIN_A = 3'd2,
    JOIN_DRAIN_B = 3'd3,
    JOIN_TERM    = 3'd4
  } fsm_join;

endpackage

// File: rtl/index_skip_join_if.sv
// Stream bundle between the two index readers, the join unit and the PE side.
// Handshake: an input head is consumed in the cycle O_Ready_x is high (O_Ready_x
// implies I_Valid_x); an output beat transfers on a cycle with O_Valid & I_Ready,
// and all O_* beat fields hold steady while O_Valid & !I_Ready.
interface index_skip_join_if #(
  parameter int WIDTH_DATA  = 32,
  parameter int WIDTH_INDEX = 8
);
  logic                   I_Valid_A, I_Valid_B;
  logic [WIDTH_INDEX-1:0] I_Idx_A, I_Idx_B;
  logic [WIDTH_DATA-1:0]  I_Data_A, I_Data_B;
  logic                   I_Last_A, I_Last_B;
  logic                   O_Ready_A, O_Ready_B;
  logic                   O_Valid;
  logic [WIDTH_INDEX-1:0] O_Idx;
  logic [WIDTH_DATA-1:0]  O_Data_A, O_Data_B;
  logic                   O_Last, O_Null;
  logic                   I_Ready;

  modport slave (
    input  I_Valid_A, I_Valid_B, I_Idx_A, I_Idx_B, I_Data_A, I_Data_B,
    input  I_Last_A, I_Last_B, I_Ready,
    output O_Ready_A, O_Ready_B, O_Valid, O_Idx, O_Data_A, O_Data_B, O_Last, O_Null
  );

  modport master (
    output I_Valid_A, I_Valid_B, I_Idx_A, I_Idx_B, I_Data_A, I_Data_B,
    output I_Last_A, I_Last_B, I_Ready,
    input  O_Ready_A, O_Ready_B, O_Valid, O_Idx, O_Data_A, O_Data_B, O_Last, O_Null
  );
endinterface

// File: rtl/index_join_fifo.sv
// First-word-fall-through output buffer; head fields read as zero while empty.
module index_join_fifo #(
  parameter int WIDTH_PAYLOAD = 74,
  parameter int DEPTH_BUF     = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH_PAYLOAD-1:0] wr_payload,
  output logic                     full,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH_PAYLOAD-1:0] rd_payload
);
  localparam int AW = $clog2(DEPTH_BUF);

  logic [WIDTH_PAYLOAD-1:0] mem [DEPTH_BUF];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [AW:0]              count;
  logic                     rd_fire;

  assign rd_valid   = (count != '0);
  assign rd_fire    = rd_valid & rd_ready;
  // A pop in the same cycle frees a slot, so full-and-draining accepts a write.
  assign full       = (count == (AW+1)'(DEPTH_BUF)) & ~rd_fire;
  assign rd_payload = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_payload;
  end
endmodule

// File: rtl/index_skip_join.sv
// Merges two sorted sparse streams by head index (intersection or union),
// counting matches, flagging out-of-order indices and terminating each vector.
module index_skip_join
  import pkg_extend_index::*;
#(
  parameter int WIDTH_DATA  = 32,
  parameter int WIDTH_INDEX = pkg_extend_index::WIDTH_INDEX,
  parameter int DEPTH_BUF   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   I_Mode,
  index_skip_join_if.slave       join_bus,
  output logic [WIDTH_INDEX:0]   O_Count,
  output logic                   O_Busy,
  output logic                   O_Err,
  output fsm_join                O_State
);
  localparam int WP = 2 + WIDTH_INDEX + 2 * WIDTH_DATA;

  fsm_join                state, state_next;
  logic                   mode_q, last_sent_q, err_q;
  logic [WIDTH_INDEX:0]   count_q;
  logic [WIDTH_INDEX-1:0] prev_a, prev_b;
  logic                   seen_a, seen_b;
  logic                   start, take_a, take_b, end_a, end_b;
  logic                   wr_en, wr_last, wr_null, fifo_full, rd_valid;
  logic [WIDTH_INDEX-1:0] wr_idx;
  logic [WIDTH_DATA-1:0]  wr_data_a, wr_data_b;
  logic [WP-1:0]          rd_payload;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    take_a     = 1'b0;
    take_b     = 1'b0;
    end_a      = 1'b0;
    end_b      = 1'b0;
    wr_en      = 1'b0;
    wr_last    = 1'b0;
    wr_null    = 1'b0;
    wr_idx     = '0;
    wr_data_a  = '0;
    wr_data_b  = '0;
    unique case (state)
      JOIN_IDLE: begin
        if (join_bus.I_Valid_A & join_bus.I_Valid_B) begin
          start      = 1'b1;
          state_next = JOIN_CMP;
        end
      end
      JOIN_CMP: begin
        if (join_bus.I_Valid_A & join_bus.I_Valid_B & ~fifo_full) begin
          take_a    = (join_bus.I_Idx_A <= join_bus.I_Idx_B);
          take_b    = (join_bus.I_Idx_B <= join_bus.I_Idx_A);
          end_a     = take_a & join_bus.I_Last_A;
          end_b     = take_b & join_bus.I_Last_B;
          wr_en     = (take_a & take_b) | (mode_q == JOIN_UNION);
          wr_idx    = take_a ? join_bus.I_Idx_A : join_bus.I_Idx_B;
          wr_data_a = take_a ? join_bus.I_Data_A : '0;
          wr_data_b = take_b ? join_bus.I_Data_B : '0;
          wr_last   = end_a & end_b;
          if (end_a & end_b) state_next = JOIN_TERM;
          else if (end_a)    state_next = JOIN_DRAIN_B;
          else if (end_b)    state_next = JOIN_DRAIN_A;
        end
      end
      JOIN_DRAIN_A: begin
        if (join_bus.I_Valid_A & ~fifo_full) begin
          take_a    = 1'b1;
          wr_en     = (mode_q == JOIN_UNION);
          wr_idx    = join_bus.I_Idx_A;
          wr_data_a = join_bus.I_Data_A;
          wr_last   = join_bus.I_Last_A;
          if (join_bus.I_Last_A) state_next = JOIN_TERM;
        end
      end
      JOIN_DRAIN_B: begin
        if (join_bus.I_Valid_B & ~fifo_full) begin
          take_b    = 1'b1;
          wr_en     = (mode_q == JOIN_UNION);
          wr_idx    = join_bus.I_Idx_B;
          wr_data_b = join_bus.I_Data_B;
          wr_last   = join_bus.I_Last_B;
          if (join_bus.I_Last_B) state_next = JOIN_TERM;
        end
      end
      JOIN_TERM: begin
        // A vector whose final beat was not Last-tagged gets a null terminator.
        if (last_sent_q) begin
          state_next = JOIN_IDLE;
        end else if (~fifo_full) begin
          wr_en      = 1'b1;
          wr_last    = 1'b1;
          wr_null    = 1'b1;
          state_next = JOIN_IDLE;
        end
      end
      default: state_next = JOIN_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= JOIN_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mode_q      <= JOIN_INTERSECT;
      last_sent_q <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
      prev_a      <= '0;
      prev_b      <= '0;
      seen_a      <= 1'b0;
      seen_b      <= 1'b0;
    end else begin
      if (start) begin
        mode_q      <= I_Mode;
        count_q     <= '0;
        last_sent_q <= 1'b0;
        seen_a      <= 1'b0;
        seen_b      <= 1'b0;
      end
      if (take_a & take_b & (count_q != '1)) count_q <= count_q + 1'b1;
      if (wr_en & wr_last) last_sent_q <= 1'b1;
      if (take_a) begin
        prev_a <= join_bus.I_Idx_A;
        seen_a <= 1'b1;
        if (seen_a && (join_bus.I_Idx_A <= prev_a)) err_q <= 1'b1;
      end
      if (take_b) begin
        prev_b <= join_bus.I_Idx_B;
        seen_b <= 1'b1;
        if (seen_b && (join_bus.I_Idx_B <= prev_b)) err_q <= 1'b1;
      end
    end
  end

  index_join_fifo #(
    .WIDTH_PAYLOAD (WP),
    .DEPTH_BUF     (DEPTH_BUF)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_payload ({wr_last, wr_null, wr_idx, wr_data_a, wr_data_b}),
    .full       (fifo_full),
    .rd_ready   (join_bus.I_Ready),
    .rd_valid   (rd_valid),
    .rd_payload (rd_payload)
  );

  assign join_bus.O_Ready_A = take_a;
  assign join_bus.O_Ready_B = take_b;
  assign join_bus.O_Valid   = rd_valid;
  assign {join_bus.O_Last, join_bus.O_Null, join_bus.O_Idx,
          join_bus.O_Data_A, join_bus.O_Data_B} = rd_payload;

  assign O_Count = count_q;
  assign O_Busy  = (state != JOIN_IDLE);
  assign O_Err   = err_q;
  assign O_State = state;
endmodule
